// File: rtl/word_stream_fetch.sv
// rtl/word_stream_fetch.sv - fetches a run of BRAM words onto a valid/ready stream
//
// Reads num_words consecutive 32-bit words from a synchronous BRAM, starting at
// base_addr and wrapping modulo 2**ADDR_W. The words are presented in address
// order on dout. A 2-entry buffer hides the BRAM's 1-cycle read latency, so the
// block sustains one word per cycle under no backpressure.
//
// Build option: define WORD_STREAM_HALF_SWAP_EN to exchange the 16-bit halves of
// every word on its way into the buffer.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     command pulse, honoured only in IDLE
//   base_addr, num_words      run description, latched on an accepted start
//   bram_en, bram_addr        BRAM read port request
//   bram_rdata                BRAM read data, valid 1 cycle after bram_en
//   dout, dout_valid          stream word and its valid flag
//   dout_ready                the consumer takes dout this cycle
//   dout_last                 dout is the final word of the run
//   busy                      a run is in progress
//   done                      one-cycle pulse when a run completes
module word_stream_fetch #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [31:0]       bram_rdata,
    output logic [31:0]       dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  accepted;

    // A read issued last cycle; its data is on bram_rdata this cycle.
    logic              inflight;
    logic              inflight_last;

    logic [31:0]       buf_data [2];
    logic [1:0]        buf_last;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic              push;
    logic              pop;
    logic              rd_en;
    logic              last_issue;
    logic              run_end;
    logic              done_set;
    logic [2:0]        occ_after;
    logic [31:0]       push_data;

`ifdef WORD_STREAM_HALF_SWAP_EN
    assign push_data = {bram_rdata[15:0], bram_rdata[31:16]};
`else
    assign push_data = bram_rdata;
`endif

    assign push       = inflight;
    assign dout_valid = (count != 2'd0);
    assign pop        = dout_valid & dout_ready;
    assign last_issue = (issued == len - LEN_W'(1));
    // The run ends on the acceptance count, not on the issue count.
    assign run_end    = pop && (accepted == len - LEN_W'(1));

    // Buffered words plus the in-flight read, after this cycle's pop. A new read
    // is allowed only while this stays below the buffer depth, so data returning
    // from the BRAM always has a free slot.
    assign occ_after  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    assign dout       = dout_valid ? buf_data[rd_ptr] : 32'd0;
    assign dout_last  = dout_valid & buf_last[rd_ptr];
    assign bram_addr  = cur_addr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start && (num_words != '0)) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rd_en && last_issue) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (run_end) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rd_en    = 1'b0;
        bram_en  = 1'b0;
        busy     = 1'b0;
        done_set = 1'b0;
        case (state)
            S_IDLE: begin
                // A zero-length run completes immediately without any reads.
                done_set = start && (num_words == '0);
            end
            S_FETCH: begin
                busy    = 1'b1;
                rd_en   = (issued != len) && (occ_after < 3'd2);
                bram_en = rd_en;
            end
            S_DRAIN: begin
                busy     = 1'b1;
                done_set = run_end;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Run bookkeeping and buffer control
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr      <= '0;
            len           <= '0;
            issued        <= '0;
            accepted      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_last      <= 2'b00;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= 2'd0;
            done          <= 1'b0;
        end else begin
            done          <= done_set;
            inflight      <= rd_en;
            inflight_last <= rd_en && last_issue;

            if (state == S_IDLE && start) begin
                cur_addr <= base_addr;
                len      <= num_words;
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (rd_en) begin
                    // Natural overflow gives the modulo 2**ADDR_W wrap.
                    cur_addr <= cur_addr + ADDR_W'(1);
                    issued   <= issued + LEN_W'(1);
                end
                if (pop) begin
                    accepted <= accepted + LEN_W'(1);
                end
            end

            if (push) begin
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage needs no reset: dout is gated by dout_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_word_stream_fetch.sv
// tb/tb_word_stream_fetch.sv - directed self-checking bench for word_stream_fetch
module tb_word_stream_fetch;

    localparam int ADDR_W = 6;
    localparam int LEN_W  = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  num_words = '0;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_rdata = '0;
    logic [31:0]       dout;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic              dout_last;
    logic              busy;
    logic              done;

    logic [31:0]       mem [64];
    int                n_cmp = 0;
    int                n_err = 0;

    word_stream_fetch #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_rdata (bram_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) bram_rdata <= mem[bram_addr];
    end

    // Apply ready at the falling edge, then sample 1 time unit later.
    task automatic cyc(input logic rdy);
        @(negedge clk);
        dout_ready = rdy;
        #1;
    endtask

    // Present start for exactly one rising edge.
    task automatic launch(input int b, input int n);
        @(negedge clk);
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        num_words = LEN_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        n_cmp++;
        if ({bram_en, bram_addr, dout_valid, dout_last, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got en=%0b addr=%0d v=%0b l=%0b busy=%0b done=%0b want all 0",
                     bram_en, bram_addr, dout_valid, dout_last, busy, done);
        end
        n_cmp++;
        if (dout !== 32'd0) begin
            n_err++;
            $display("FAIL reset_dout: got %h want 0", dout);
        end
        rst = 1'b0;
        cyc(1'b0);
        n_cmp++;
        if ({bram_en, dout_valid, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_after_reset: got en=%0b v=%0b busy=%0b done=%0b want 0",
                     bram_en, dout_valid, busy, done);
        end
    endtask

    task automatic test_basic();
        launch(0, 4);
        for (int c = 1; c <= 9; c++) begin
            cyc(1'b1);
            n_cmp++;
            if (dout_valid !== (c >= 3 && c <= 6)) begin
                n_err++;
                $display("FAIL basic_valid c=%0d: got %0b", c, dout_valid);
            end
            if (c >= 3 && c <= 6) begin
                n_cmp++;
                if (dout !== 32'(32'h100 + c - 3)) begin
                    n_err++;
                    $display("FAIL basic_dout c=%0d: got %h want %h", c, dout, 32'(32'h100 + c - 3));
                end
                n_cmp++;
                if (dout_last !== (c == 6)) begin
                    n_err++;
                    $display("FAIL basic_last c=%0d: got %0b want %0b", c, dout_last, (c == 6));
                end
            end
            n_cmp++;
            if (bram_en !== (c <= 4)) begin
                n_err++;
                $display("FAIL basic_en c=%0d: got %0b want %0b", c, bram_en, (c <= 4));
            end
            if (c <= 4) begin
                n_cmp++;
                if (bram_addr !== ADDR_W'(c - 1)) begin
                    n_err++;
                    $display("FAIL basic_addr c=%0d: got %0d want %0d", c, bram_addr, c - 1);
                end
            end
            n_cmp++;
            if (done !== (c == 7)) begin
                n_err++;
                $display("FAIL basic_done c=%0d: got %0b want %0b", c, done, (c == 7));
            end
            n_cmp++;
            if (busy !== (c <= 6)) begin
                n_err++;
                $display("FAIL basic_busy c=%0d: got %0b want %0b", c, busy, (c <= 6));
            end
        end
    endtask

    task automatic test_backpressure();
        int          issued = 0;
        int          got = 0;
        int          outst = 0;
        int          last_acc = -100;
        int          done_cyc = -1;
        logic        rdy;
        logic        pop;
        logic        prev_hold = 1'b0;
        logic [31:0] prev_d = '0;
        logic        prev_l = 1'b0;
        launch(5, 6);
        for (int k = 0; k < 80 && done_cyc < 0; k++) begin
            rdy = ((k % 4) == 0) || ((k % 4) == 3);
            cyc(rdy);
            if (prev_hold) begin
                n_cmp++;
                if (dout_valid !== 1'b1 || dout !== prev_d || dout_last !== prev_l) begin
                    n_err++;
                    $display("FAIL bp_hold k=%0d: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                             k, dout_valid, dout, dout_last, prev_d, prev_l);
                end
            end
            if (bram_en === 1'b1) begin
                n_cmp++;
                if (bram_addr !== ADDR_W'(5 + issued)) begin
                    n_err++;
                    $display("FAIL bp_addr: got %0d want %0d", bram_addr, 5 + issued);
                end
                issued++;
            end
            pop = dout_valid & rdy;
            if (pop === 1'b1) begin
                n_cmp++;
                if (dout !== 32'(32'h105 + got)) begin
                    n_err++;
                    $display("FAIL bp_dout word=%0d: got %h want %h", got, dout, 32'(32'h105 + got));
                end
                n_cmp++;
                if (dout_last !== (got == 5)) begin
                    n_err++;
                    $display("FAIL bp_last word=%0d: got %0b want %0b", got, dout_last, (got == 5));
                end
                got++;
                last_acc = k;
            end
            outst = outst + int'(bram_en) - int'(pop);
            n_cmp++;
            if (outst > 2) begin
                n_err++;
                $display("FAIL bp_outstanding k=%0d: got %0d want <=2", k, outst);
            end
            if (done === 1'b1) done_cyc = k;
            prev_hold = dout_valid & ~rdy;
            prev_d    = dout;
            prev_l    = dout_last;
        end
        n_cmp++;
        if (got != 6) begin
            n_err++;
            $display("FAIL bp_count: got %0d words want 6", got);
        end
        n_cmp++;
        if (issued != 6) begin
            n_err++;
            $display("FAIL bp_reads: got %0d reads want 6", issued);
        end
        n_cmp++;
        if (done_cyc != last_acc + 1) begin
            n_err++;
            $display("FAIL bp_done: got cycle %0d want %0d", done_cyc, last_acc + 1);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] addrs [$];
        logic [31:0]       words [$];
        int                exp_a [4] = '{62, 63, 0, 1};
        logic [31:0]       exp_d [4] = '{32'h13E, 32'h13F, 32'h100, 32'h101};
        bit                seen_done = 1'b0;
        launch(62, 4);
        for (int c = 1; c <= 20 && !seen_done; c++) begin
            cyc(1'b1);
            if (bram_en === 1'b1) addrs.push_back(bram_addr);
            if (dout_valid === 1'b1) words.push_back(dout);
            if (done === 1'b1) seen_done = 1'b1;
        end
        n_cmp++;
        if (addrs.size() != 4 || words.size() != 4 || !seen_done) begin
            n_err++;
            $display("FAIL wrap_sizes: got reads=%0d words=%0d done=%0b want 4 4 1",
                     addrs.size(), words.size(), seen_done);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (addrs[i] !== ADDR_W'(exp_a[i])) begin
                    n_err++;
                    $display("FAIL wrap_addr %0d: got %0d want %0d", i, addrs[i], exp_a[i]);
                end
                n_cmp++;
                if (words[i] !== exp_d[i]) begin
                    n_err++;
                    $display("FAIL wrap_dout %0d: got %h want %h", i, words[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_zero();
        launch(9, 0);
        for (int c = 1; c <= 4; c++) begin
            cyc(1'b1);
            n_cmp++;
            if (bram_en !== 1'b0 || dout_valid !== 1'b0) begin
                n_err++;
                $display("FAIL zero_activity c=%0d: got en=%0b v=%0b want 0 0", c, bram_en, dout_valid);
            end
            n_cmp++;
            if (done !== (c == 1)) begin
                n_err++;
                $display("FAIL zero_done c=%0d: got %0b want %0b", c, done, (c == 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        launch(0, 10);
        for (int c = 1; c <= 20 && got < 3; c++) begin
            cyc(1'b1);
            if (dout_valid === 1'b1) got++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bram_en, bram_addr, dout, dout_valid, dout_last, busy, done} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got en=%0b addr=%0d d=%h v=%0b l=%0b busy=%0b done=%0b want all 0",
                     bram_en, bram_addr, dout, dout_valid, dout_last, busy, done);
        end
        for (int c = 1; c <= 4; c++) begin
            cyc(1'b1);
            n_cmp++;
            if ({bram_en, dout_valid, busy, done} !== 4'b0000) begin
                n_err++;
                $display("FAIL mid_reset_quiet c=%0d: got en=%0b v=%0b busy=%0b done=%0b want 0",
                         c, bram_en, dout_valid, busy, done);
            end
        end
        launch(0, 2);
        for (int c = 1; c <= 6; c++) begin
            cyc(1'b1);
            n_cmp++;
            if (dout_valid !== (c == 3 || c == 4)) begin
                n_err++;
                $display("FAIL restart_valid c=%0d: got %0b", c, dout_valid);
            end
            if (c == 3 || c == 4) begin
                n_cmp++;
                if (dout !== 32'(32'h100 + c - 3) || dout_last !== (c == 4)) begin
                    n_err++;
                    $display("FAIL restart_dout c=%0d: got %h l=%0b want %h l=%0b",
                             c, dout, dout_last, 32'(32'h100 + c - 3), (c == 4));
                end
            end
            n_cmp++;
            if (done !== (c == 5)) begin
                n_err++;
                $display("FAIL restart_done c=%0d: got %0b want %0b", c, done, (c == 5));
            end
        end
    endtask

    task automatic test_half_swap();
        logic [31:0] exp;
`ifdef WORD_STREAM_HALF_SWAP_EN
        exp = 32'hABCD1234;
`else
        exp = 32'h1234ABCD;
`endif
        mem[0] = 32'h1234ABCD;
        launch(0, 1);
        for (int c = 1; c <= 4; c++) begin
            cyc(1'b1);
            n_cmp++;
            if (dout_valid !== (c == 3)) begin
                n_err++;
                $display("FAIL swap_valid c=%0d: got %0b", c, dout_valid);
            end
            if (c == 3) begin
                n_cmp++;
                if (dout !== exp || dout_last !== 1'b1) begin
                    n_err++;
                    $display("FAIL swap_dout: got %h l=%0b want %h l=1", dout, dout_last, exp);
                end
            end
            n_cmp++;
            if (done !== (c == 4)) begin
                n_err++;
                $display("FAIL swap_done c=%0d: got %0b want %0b", c, done, (c == 4));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h100 + i;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_reset_mid();
        test_half_swap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
